// File: rtl/axi_mem_pkg.sv
// ---------------------------------------------------------------------------
// axi_mem_pkg
// Shared types and constants for the AXI burst memory responder.
//   rs_state_t  : responder FSM states
//   OKAY/SLVERR : AXI response codes driven on rresp/bresp
//   BYTE_OFF_W  : byte-offset bits dropped from an AXI byte address to form a
//                 word index (beats are always 8 bytes wide)
//   LEN_W       : width of AXI arlen/awlen
// ---------------------------------------------------------------------------
package axi_mem_pkg;

   typedef enum logic [1:0] {
      RS_IDLE  = 2'd0,
      RS_READ  = 2'd1,
      RS_WRITE = 2'd2,
      RS_WRESP = 2'd3
   } rs_state_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   localparam int BYTE_OFF_W = 3;
   localparam int LEN_W      = 8;

endpackage

// File: rtl/axi_interface_if.sv
// ---------------------------------------------------------------------------
// axi_interface_if
// AXI4 signal bundle used by the burst memory responder.
//   rd_slv modport : AR request in, R beats out
//   wr_slv modport : AW request and W beats in, B response out
// Parameters: ADDR_W (byte address width), DATA_W (beat width), ID_W.
// ---------------------------------------------------------------------------
interface axi_interface_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4
) ();

   // AR channel
   logic              arvalid;
   logic              arready;
   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;

   // R channel
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [ID_W-1:0]   rid;
   logic [1:0]        rresp;
   logic              rlast;

   // AW channel
   logic              awvalid;
   logic              awready;
   logic [ID_W-1:0]   awid;
   logic [ADDR_W-1:0] awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;

   // W channel
   logic                wvalid;
   logic                wready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;

   // B channel
   logic              bvalid;
   logic              bready;
   logic [ID_W-1:0]   bid;
   logic [1:0]        bresp;

   modport rd_slv (
      input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
      output arready, rvalid, rdata, rid, rresp, rlast
   );

   modport wr_slv (
      input  awvalid, awid, awaddr, awlen, awsize, awburst,
             wvalid, wdata, wstrb, wlast, bready,
      output awready, wready, bvalid, bid, bresp
   );

endinterface

// File: rtl/strb_mem_array.sv
// ---------------------------------------------------------------------------
// strb_mem_array
// Byte-strobed word memory: one synchronous write port, one combinational
// read port. Contents are never reset.
//   clk   : write clock
//   we    : write enable for the addressed word
//   waddr : write word index
//   wdata : write data
//   wstrb : per-byte write enables (bit b covers wdata[8*b +: 8])
//   raddr : read word index
//   rdata : read data, combinational from raddr
// ---------------------------------------------------------------------------
module strb_mem_array #(
   parameter int DATA_W      = 64,
   parameter int DEPTH_WORDS = 1024,
   localparam int IDX_W      = $clog2(DEPTH_WORDS),
   localparam int STRB_W     = DATA_W / 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) begin
               mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/axi_burst_mem_responder.sv
// ---------------------------------------------------------------------------
// axi_burst_mem_responder
// Single-outstanding AXI4 slave backed by a byte-strobed memory. Every burst
// is treated as INCR of DATA_W-wide beats; arsize/arburst/awsize/awburst and
// wlast are ignored and the write beat count comes from awlen. Reads win over
// writes when both requests arrive together. The word pointer wraps modulo
// DEPTH_WORDS.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset (memory contents kept)
//   axi_read_in  : AR/R channels (axi_interface_if.rd_slv)
//   axi_write_in : AW/W/B channels (axi_interface_if.wr_slv)
//
// Build option:
//   AXI_MEM_BOUNDS_CHECK_EN - bursts whose start+len runs past the last word
//   answer SLVERR on R/B, read back zeros and drop every write beat, while
//   still completing all handshakes. Undefined: no range check, pointer wraps.
// ---------------------------------------------------------------------------
module axi_burst_mem_responder
   import axi_mem_pkg::*;
#(
   parameter int DATA_W      = 64,
   parameter int DEPTH_WORDS = 1024,
   parameter int ID_W        = 4
) (
   input logic             clk,
   input logic             rst,
   axi_interface_if.rd_slv axi_read_in,
   axi_interface_if.wr_slv axi_write_in
);

   localparam int IDX_W  = $clog2(DEPTH_WORDS);
   localparam int STRB_W = DATA_W / 8;

   rs_state_t         state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [LEN_W-1:0]  beat_q, beat_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [ID_W-1:0]   id_q, id_d;

   logic [IDX_W-1:0]  ar_idx, aw_idx;
   logic              arready, awready, wready, rvalid, bvalid;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_rdata, rdata_sel;
   logic              wr_block;
   logic [1:0]        resp;
   logic              unused_inputs;

   assign ar_idx = axi_read_in.araddr[BYTE_OFF_W +: IDX_W];
   assign aw_idx = axi_write_in.awaddr[BYTE_OFF_W +: IDX_W];

   // Burst type/size and wlast carry no information for this responder.
   assign unused_inputs = ^{axi_read_in.araddr, axi_read_in.arsize,
                            axi_read_in.arburst, axi_write_in.awaddr,
                            axi_write_in.awsize, axi_write_in.awburst,
                            axi_write_in.wlast};

`ifdef AXI_MEM_BOUNDS_CHECK_EN
   localparam int SUM_W = IDX_W + LEN_W + 1;

   logic err_q, err_d;
   logic ar_oob, aw_oob;

   function automatic logic burst_oob(input logic [IDX_W-1:0] start,
                                      input logic [LEN_W-1:0] len);
      logic [SUM_W-1:0] last_word;
      last_word = SUM_W'(start) + SUM_W'(len);
      return last_word > SUM_W'(DEPTH_WORDS - 1);
   endfunction

   assign ar_oob = burst_oob(ar_idx, axi_read_in.arlen);
   assign aw_oob = burst_oob(aw_idx, axi_write_in.awlen);

   // In the AW cycle the error flag is not registered yet, so beat 0 is
   // screened against the incoming request directly.
   assign wr_block  = (state_q == RS_IDLE) ? aw_oob : err_q;
   assign resp      = err_q ? SLVERR : OKAY;
   assign rdata_sel = err_q ? '0 : mem_rdata;
`else
   assign wr_block  = 1'b0;
   assign resp      = OKAY;
   assign rdata_sel = mem_rdata;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      beat_d    = beat_q;
      id_d      = id_q;
      len_d     = len_q;
`ifdef AXI_MEM_BOUNDS_CHECK_EN
      err_d     = err_q;
`endif
      arready   = 1'b0;
      awready   = 1'b0;
      wready    = 1'b0;
      rvalid    = 1'b0;
      bvalid    = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = ptr_q;

      unique case (state_q)
         RS_IDLE: begin
            // Readies are gated by rst so nothing handshakes while held in reset.
            arready = rst;
            awready = rst && !axi_read_in.arvalid;
            // Beat 0 may ride along with the AW handshake.
            wready  = awready && axi_write_in.awvalid;

            if (axi_read_in.arvalid && arready) begin
               state_d = RS_READ;
               ptr_d   = ar_idx;
               beat_d  = '0;
               id_d    = axi_read_in.arid;
               len_d   = axi_read_in.arlen;
`ifdef AXI_MEM_BOUNDS_CHECK_EN
               err_d   = ar_oob;
`endif
            end else if (axi_write_in.awvalid && awready) begin
               id_d      = axi_write_in.awid;
               len_d     = axi_write_in.awlen;
               mem_waddr = aw_idx;
`ifdef AXI_MEM_BOUNDS_CHECK_EN
               err_d     = aw_oob;
`endif
               if (axi_write_in.wvalid) begin
                  mem_we = !wr_block;
                  if (axi_write_in.awlen == '0) begin
                     state_d = RS_WRESP;
                     ptr_d   = aw_idx;
                     beat_d  = '0;
                  end else begin
                     state_d = RS_WRITE;
                     ptr_d   = aw_idx + IDX_W'(1);
                     beat_d  = LEN_W'(1);
                  end
               end else begin
                  state_d = RS_WRITE;
                  ptr_d   = aw_idx;
                  beat_d  = '0;
               end
            end
         end

         RS_READ: begin
            rvalid = 1'b1;
            if (axi_read_in.rready) begin
               if (beat_q == len_q) begin
                  state_d = RS_IDLE;
               end else begin
                  ptr_d  = ptr_q + IDX_W'(1);
                  beat_d = beat_q + LEN_W'(1);
               end
            end
         end

         RS_WRITE: begin
            wready = 1'b1;
            if (axi_write_in.wvalid) begin
               mem_we = !wr_block;
               if (beat_q == len_q) begin
                  state_d = RS_WRESP;
               end else begin
                  ptr_d  = ptr_q + IDX_W'(1);
                  beat_d = beat_q + LEN_W'(1);
               end
            end
         end

         RS_WRESP: begin
            bvalid = 1'b1;
            if (axi_write_in.bready) begin
               state_d = RS_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RS_IDLE;
         ptr_q   <= '0;
         beat_q  <= '0;
         id_q    <= '0;
         len_q   <= '0;
`ifdef AXI_MEM_BOUNDS_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         beat_q  <= beat_d;
         id_q    <= id_d;
         len_q   <= len_d;
`ifdef AXI_MEM_BOUNDS_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   strb_mem_array #(
      .DATA_W      (DATA_W),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (axi_write_in.wdata),
      .wstrb (axi_write_in.wstrb),
      .raddr (ptr_q),
      .rdata (mem_rdata)
   );

   assign axi_read_in.arready  = arready;
   assign axi_read_in.rvalid   = rvalid;
   assign axi_read_in.rdata    = rdata_sel;
   assign axi_read_in.rid      = id_q;
   assign axi_read_in.rresp    = resp;
   assign axi_read_in.rlast    = rvalid && (beat_q == len_q);

   assign axi_write_in.awready = awready;
   assign axi_write_in.wready  = wready;
   assign axi_write_in.bvalid  = bvalid;
   assign axi_write_in.bid     = id_q;
   assign axi_write_in.bresp   = resp;

endmodule

// File: tb/tb_axi_burst_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_mem_responder
// Directed bench for axi_burst_mem_responder. Inputs change on the falling
// edge, outputs are sampled 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_axi_burst_mem_responder;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   axi_interface_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) axi_if ();

   axi_burst_mem_responder #(
      .DATA_W      (64),
      .DEPTH_WORDS (1024),
      .ID_W        (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .axi_read_in  (axi_if),
      .axi_write_in (axi_if)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Captured read burst
   logic [63:0] rd_data [256];
   logic        rd_last [256];
   logic [3:0]  rd_id   [256];
   logic [1:0]  rd_resp [256];
   int          rd_cyc  [256];
   int          rd_n;
   int          stall_c = -1;
   logic [63:0] stall_data;

   // Captured write burst
   int          wr_acc;
   int          wr_bcnt;
   logic [1:0]  wr_resp;
   logic [3:0]  wr_bid;

   task automatic idle_inputs();
      axi_if.arvalid = 1'b0; axi_if.arid = '0; axi_if.araddr = '0;
      axi_if.arlen = '0; axi_if.arsize = 3'd3; axi_if.arburst = 2'd1;
      axi_if.rready = 1'b0;
      axi_if.awvalid = 1'b0; axi_if.awid = '0; axi_if.awaddr = '0;
      axi_if.awlen = '0; axi_if.awsize = 3'd3; axi_if.awburst = 2'd1;
      axi_if.wvalid = 1'b0; axi_if.wdata = '0; axi_if.wstrb = '0;
      axi_if.wlast = 1'b0; axi_if.bready = 1'b0;
   endtask

   // Write burst with wvalid high from the AW cycle; beat i carries d0+i*step.
   task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [63:0] d0, input logic [63:0] step,
                              input logic [7:0] strb, input logic [3:0] id);
      logic aw_hs, w_hs;
      wr_acc = 0; wr_bcnt = 0; wr_resp = 'x; wr_bid = 'x;
      @(negedge clk);
      axi_if.bready = 1'b1;
      axi_if.awaddr = addr; axi_if.awlen = len; axi_if.awid = id;
      axi_if.awvalid = 1'b1;
      axi_if.wvalid = 1'b1; axi_if.wdata = d0; axi_if.wstrb = strb;
      axi_if.wlast = 1'b0;
      for (int c = 0; c < 300 && wr_bcnt == 0; c++) begin
         #1;
         aw_hs = axi_if.awvalid && axi_if.awready;
         w_hs  = axi_if.wvalid && axi_if.wready;
         if (axi_if.bvalid) begin
            wr_bcnt++;
            wr_resp = axi_if.bresp;
            wr_bid  = axi_if.bid;
         end
         @(negedge clk);
         if (aw_hs) axi_if.awvalid = 1'b0;
         if (w_hs) begin
            wr_acc++;
            if (wr_acc == int'(len) + 1) axi_if.wvalid = 1'b0;
            else axi_if.wdata = d0 + 64'(wr_acc) * step;
         end
      end
      axi_if.awvalid = 1'b0;
      axi_if.wvalid  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (axi_if.bvalid) wr_bcnt++;
         @(negedge clk);
      end
      axi_if.bready = 1'b0;
   endtask

   // Read burst; rready is low only in loop cycle stall_c.
   task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                             input logic [3:0] id);
      logic ar_hs, done;
      rd_n = 0; done = 1'b0;
      @(negedge clk);
      axi_if.araddr = addr; axi_if.arlen = len; axi_if.arid = id;
      axi_if.arvalid = 1'b1;
      axi_if.rready = (stall_c != 0);
      for (int c = 0; c < 300 && !done; c++) begin
         #1;
         ar_hs = axi_if.arvalid && axi_if.arready;
         if (c == stall_c) stall_data = axi_if.rdata;
         if (axi_if.rvalid && axi_if.rready && rd_n < 256) begin
            rd_data[rd_n] = axi_if.rdata;
            rd_last[rd_n] = axi_if.rlast;
            rd_id[rd_n]   = axi_if.rid;
            rd_resp[rd_n] = axi_if.rresp;
            rd_cyc[rd_n]  = c;
            rd_n++;
            if (axi_if.rlast) done = 1'b1;
         end
         @(negedge clk);
         if (ar_hs) axi_if.arvalid = 1'b0;
         axi_if.rready = (c + 1 != stall_c);
      end
      axi_if.arvalid = 1'b0;
      axi_if.rready  = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      axi_if.arvalid = 1'b1; axi_if.awvalid = 1'b1; axi_if.wvalid = 1'b1;
      #1;
      n_tests++;
      if ({axi_if.arready, axi_if.awready, axi_if.wready} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ready: got %b, expected 000",
                  {axi_if.arready, axi_if.awready, axi_if.wready});
      end
      n_tests++;
      if ({axi_if.rvalid, axi_if.bvalid} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_valid: got %b, expected 00",
                  {axi_if.rvalid, axi_if.bvalid});
      end
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      #1;
      n_tests++;
      if ({axi_if.arready, axi_if.awready, axi_if.wready} !== 3'b110) begin
         n_fail++;
         $display("FAIL idle_ready: got %b, expected 110",
                  {axi_if.arready, axi_if.awready, axi_if.wready});
      end
   endtask

   task automatic test_write_burst();
      int errs;
      write_burst(32'h0, 8'd15, 64'd0, 64'd1, 8'hFF, 4'h5);
      n_tests++;
      if (wr_acc !== 16 || wr_bcnt !== 1) begin
         n_fail++;
         $display("FAIL wr_beats: got %0d beats %0d B, expected 16 beats 1 B",
                  wr_acc, wr_bcnt);
      end
      n_tests++;
      if (wr_resp !== 2'b00 || wr_bid !== 4'h5) begin
         n_fail++;
         $display("FAIL wr_bresp: got resp %b id %h, expected 00 id 5",
                  wr_resp, wr_bid);
      end
      write_burst(32'h80, 8'd15, 64'h100, 64'd1, 8'hFF, 4'h6);
      n_tests++;
      if (wr_acc !== 16 || wr_bcnt !== 1) begin
         n_fail++;
         $display("FAIL wr2_beats: got %0d beats %0d B, expected 16 beats 1 B",
                  wr_acc, wr_bcnt);
      end
      read_burst(32'h0, 8'd15, 4'h1);
      errs = 0;
      for (int k = 0; k < 16; k++) if (rd_data[k] !== 64'(k)) errs++;
      n_tests++;
      if (rd_n !== 16 || errs !== 0) begin
         n_fail++;
         $display("FAIL wr_readback: got %0d beats %0d bad, expected 16 beats 0 bad",
                  rd_n, errs);
      end
   endtask

   task automatic test_read_burst();
      int dbad, tbad, lbad, ibad;
      logic [63:0] exp;
      read_burst(32'h40, 8'd15, 4'hA);
      dbad = 0; tbad = 0; lbad = 0; ibad = 0;
      for (int k = 0; k < 16; k++) begin
         exp = (k < 8) ? 64'(8 + k) : 64'h100 + 64'(k - 8);
         if (rd_data[k] !== exp) dbad++;
         if (rd_cyc[k] !== k + 1) tbad++;
         if (rd_last[k] !== (k == 15)) lbad++;
         if (rd_id[k] !== 4'hA || rd_resp[k] !== 2'b00) ibad++;
      end
      n_tests++;
      if (rd_n !== 16) begin
         n_fail++;
         $display("FAIL rd_count: got %0d, expected 16", rd_n);
      end
      n_tests++;
      if (dbad !== 0) begin
         n_fail++;
         $display("FAIL rd_data: got %0d bad beats, expected 0", dbad);
      end
      n_tests++;
      if (tbad !== 0) begin
         n_fail++;
         $display("FAIL rd_latency: got %0d late beats (beat0 cycle %0d), expected 0 (cycle 1)",
                  tbad, rd_cyc[0]);
      end
      n_tests++;
      if (lbad !== 0) begin
         n_fail++;
         $display("FAIL rd_rlast: got %0d wrong rlast, expected 0", lbad);
      end
      n_tests++;
      if (ibad !== 0) begin
         n_fail++;
         $display("FAIL rd_rid: got %0d beats with wrong rid/rresp, expected 0", ibad);
      end
   endtask

   task automatic test_strobe();
      write_burst(32'h18, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'hFF, 4'h1);
      write_burst(32'h18, 8'd0, 64'h0, 64'd0, 8'h0F, 4'h2);
      n_tests++;
      if (wr_acc !== 1 || wr_bcnt !== 1) begin
         n_fail++;
         $display("FAIL strb_beats: got %0d beats %0d B, expected 1 beat 1 B",
                  wr_acc, wr_bcnt);
      end
      read_burst(32'h18, 8'd0, 4'h3);
      n_tests++;
      if (rd_n !== 1 || rd_data[0] !== 64'hFFFF_FFFF_0000_0000) begin
         n_fail++;
         $display("FAIL strb_data: got %h (%0d beats), expected ffffffff00000000",
                  rd_data[0], rd_n);
      end
   endtask

   task automatic test_ar_aw_priority();
      logic [2:0] first;
      logic ar_hs, aw_hs, w_hs, got_b;
      int rbeats, viol, aw_beat, dbad;
      axi_if.bready = 1'b1;
      axi_if.rready = 1'b1;
      @(negedge clk);
      axi_if.araddr = 32'h40; axi_if.arlen = 8'd3; axi_if.arid = 4'h7;
      axi_if.arvalid = 1'b1;
      axi_if.awaddr = 32'h100; axi_if.awlen = 8'd0; axi_if.awid = 4'h9;
      axi_if.awvalid = 1'b1;
      axi_if.wvalid = 1'b1; axi_if.wdata = 64'hDEAD_BEEF_0123_4567;
      axi_if.wstrb = 8'hFF;
      rbeats = 0; viol = 0; aw_beat = -1; dbad = 0; got_b = 1'b0; first = '0;
      for (int c = 0; c < 100 && !got_b; c++) begin
         #1;
         if (c == 0) first = {axi_if.arready, axi_if.awready, axi_if.wready};
         ar_hs = axi_if.arvalid && axi_if.arready;
         aw_hs = axi_if.awvalid && axi_if.awready;
         w_hs  = axi_if.wvalid && axi_if.wready;
         if (axi_if.rvalid) begin
            if (axi_if.awready || axi_if.wready) viol++;
            if (axi_if.rdata !== 64'(8 + rbeats)) dbad++;
            rbeats++;
         end
         if (aw_hs) aw_beat = rbeats;
         if (axi_if.bvalid) got_b = 1'b1;
         @(negedge clk);
         if (ar_hs) axi_if.arvalid = 1'b0;
         if (aw_hs) axi_if.awvalid = 1'b0;
         if (w_hs)  axi_if.wvalid = 1'b0;
      end
      idle_inputs();
      n_tests++;
      if (first !== 3'b100) begin
         n_fail++;
         $display("FAIL prio_first: got ar/aw/w ready %b, expected 100", first);
      end
      n_tests++;
      if (viol !== 0 || aw_beat !== 4) begin
         n_fail++;
         $display("FAIL prio_aw_held: got %0d violations, AW after beat %0d, expected 0 and 4",
                  viol, aw_beat);
      end
      n_tests++;
      if (rbeats !== 4 || dbad !== 0 || !got_b) begin
         n_fail++;
         $display("FAIL prio_complete: got %0d beats %0d bad B=%b, expected 4 beats 0 bad B=1",
                  rbeats, dbad, got_b);
      end
      read_burst(32'h100, 8'd0, 4'h7);
      n_tests++;
      if (rd_n !== 1 || rd_data[0] !== 64'hDEAD_BEEF_0123_4567) begin
         n_fail++;
         $display("FAIL prio_wdata: got %h, expected deadbeef01234567", rd_data[0]);
      end
   endtask

   task automatic test_rready_stall();
      int dbad;
      stall_c = 4;
      read_burst(32'h40, 8'd7, 4'h2);
      stall_c = -1;
      dbad = 0;
      for (int k = 0; k < 8; k++) if (rd_data[k] !== 64'(8 + k)) dbad++;
      n_tests++;
      if (rd_n !== 8 || dbad !== 0) begin
         n_fail++;
         $display("FAIL stall_seq: got %0d beats %0d bad, expected 8 beats 0 bad",
                  rd_n, dbad);
      end
      n_tests++;
      if (stall_data !== 64'd11 || rd_cyc[3] !== 5) begin
         n_fail++;
         $display("FAIL stall_hold: got %h at cycle %0d, expected 000000000000000b at cycle 5",
                  stall_data, rd_cyc[3]);
      end
   endtask

   task automatic test_reset_mid_read();
      logic ar_hs, seen5;
      int quiet, dbad;
      axi_if.rready = 1'b1;
      @(negedge clk);
      axi_if.araddr = 32'h80; axi_if.arlen = 8'd15; axi_if.arid = 4'h3;
      axi_if.arvalid = 1'b1;
      seen5 = 1'b0;
      for (int c = 0; c < 40 && !seen5; c++) begin
         #1;
         ar_hs = axi_if.arvalid && axi_if.arready;
         if (axi_if.rvalid && axi_if.rdata === 64'h105) seen5 = 1'b1;
         if (!seen5) begin
            @(negedge clk);
            if (ar_hs) axi_if.arvalid = 1'b0;
         end
      end
      axi_if.arvalid = 1'b0;
      n_tests++;
      if (!seen5) begin
         n_fail++;
         $display("FAIL rstmid_beat5: got no beat 5, expected data 0x105");
      end
      #2;
      rst = 1'b0;
      #1;
      n_tests++;
      if (axi_if.rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_drop: got rvalid %b, expected 0", axi_if.rvalid);
      end
      @(negedge clk);
      rst = 1'b1;
      quiet = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (axi_if.rvalid || axi_if.bvalid) quiet++;
         @(negedge clk);
      end
      n_tests++;
      if (quiet !== 0) begin
         n_fail++;
         $display("FAIL rstmid_quiet: got %0d cycles with valid after reset, expected 0",
                  quiet);
      end
      axi_if.rready = 1'b0;
      read_burst(32'h40, 8'd3, 4'hC);
      dbad = 0;
      for (int k = 0; k < 4; k++) begin
         if (rd_data[k] !== 64'(8 + k) || rd_id[k] !== 4'hC) dbad++;
      end
      n_tests++;
      if (rd_n !== 4 || dbad !== 0 || rd_last[3] !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_next: got %0d beats %0d bad, expected 4 beats 0 bad",
                  rd_n, dbad);
      end
   endtask

   task automatic test_wrap();
      logic [1:0]  exp_resp;
      logic [63:0] exp_top [4];
      logic [63:0] exp_w0, exp_w1;
      int dbad;
`ifdef AXI_MEM_BOUNDS_CHECK_EN
      exp_resp = 2'b10;
      for (int k = 0; k < 4; k++) exp_top[k] = 64'd0;
      exp_w0 = 64'd0;
      exp_w1 = 64'd1;
`else
      exp_resp = 2'b00;
      for (int k = 0; k < 4; k++) exp_top[k] = 64'h500 + 64'(k);
      exp_w0 = 64'h502;
      exp_w1 = 64'h503;
`endif
      write_burst(32'h1FF0, 8'd3, 64'h500, 64'd1, 8'hFF, 4'h2);
      n_tests++;
      if (wr_acc !== 4 || wr_bcnt !== 1 || wr_resp !== exp_resp) begin
         n_fail++;
         $display("FAIL wrap_write: got %0d beats %0d B resp %b, expected 4 beats 1 B resp %b",
                  wr_acc, wr_bcnt, wr_resp, exp_resp);
      end
      read_burst(32'h1FF0, 8'd3, 4'h1);
      dbad = 0;
      for (int k = 0; k < 4; k++) begin
         if (rd_data[k] !== exp_top[k] || rd_resp[k] !== exp_resp) dbad++;
      end
      n_tests++;
      if (rd_n !== 4 || dbad !== 0) begin
         n_fail++;
         $display("FAIL wrap_read: got %0d beats %0d bad, expected 4 beats 0 bad",
                  rd_n, dbad);
      end
      read_burst(32'h0, 8'd1, 4'h1);
      n_tests++;
      if (rd_n !== 2 || rd_data[0] !== exp_w0 || rd_data[1] !== exp_w1) begin
         n_fail++;
         $display("FAIL wrap_low: got %h %h, expected %h %h",
                  rd_data[0], rd_data[1], exp_w0, exp_w1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 2 ms");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_burst();
      test_read_burst();
      test_strobe();
      test_ar_aw_priority();
      test_rready_stall();
      test_reset_mid_read();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
